gbc_cart_header_parser: RTL and testbench

Sequencer that reads the cartridge header (ROM $0134–$014D) from the loaded image after load completes and produces the static configuration the GBC mapper needs. Outputs include mapper family, ROM/RAM bank counts, battery/RTC/rumble attributes, CGB/SGB flags and the header-checksum result. It sits between the image-load path and the mapper, and owns a simple byte-read request port into ROM storage.

---
 rtl/gbc_cart_header_parser.sv | 175 +++++++++++++++++
 tb/tb_gbc_cart_header_parser.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbc_cart_header_parser.sv
// Walks the cartridge header ($0134-$014D) over a byte-read port and latches the
// static mapper configuration plus the header-checksum verdict.
module gbc_cart_header_parser #(
  parameter int ADDR_W = 23
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              ClkEn,
  input  logic              Start,
  input  logic              Abort,
  output logic              ReadReq,
  output logic [ADDR_W-1:0] ReadAddr,
  input  logic              ReadAck,
  input  logic [7:0]        ReadData,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic              ChecksumOK,
  output logic [3:0]        MapperType,
  output logic [9:0]        RomBanks,
  output logic [4:0]        RamBanks,
  output logic              HasRAM,
  output logic              HasBattery,
  output logic              HasRTC,
  output logic              HasRumble,
  output logic [1:0]        CGBMode,
  output logic              SGBSupport
);
  localparam logic [ADDR_W-1:0] A_FIRST = ADDR_W'(16'h0134);
  localparam logic [ADDR_W-1:0] A_CGB   = ADDR_W'(16'h0143);
  localparam logic [ADDR_W-1:0] A_SGB   = ADDR_W'(16'h0146);
  localparam logic [ADDR_W-1:0] A_TYPE  = ADDR_W'(16'h0147);
  localparam logic [ADDR_W-1:0] A_ROM   = ADDR_W'(16'h0148);
  localparam logic [ADDR_W-1:0] A_RAM   = ADDR_W'(16'h0149);
  localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(16'h014D);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DECODE, S_DONE} state_t;
  state_t state, nxt;

  logic [7:0] csum, hdr_sum, cgb_b, sgb_b, cart_type, rom_code, ram_code;
  logic       abort_pend;

  logic [3:0] dec_mt;
  logic       dec_bat, dec_rtc, dec_rum, dec_ram;
  logic [4:0] dec_ramb;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else if (ClkEn) state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (Start) nxt = S_ISSUE;
      S_ISSUE:  nxt = Abort ? S_IDLE : S_WAIT;
      S_WAIT:   if (ReadAck) begin
                  if (Abort || abort_pend) nxt = S_IDLE;
                  else if (ReadAddr == A_LAST) nxt = S_DECODE;
                  else nxt = S_ISSUE;
                end
      S_DECODE: nxt = S_DONE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  assign Busy = (state != S_IDLE);
  assign Done = (state == S_DONE);

  // Cartridge-type byte decode; unlisted codes fall through as unsupported (15).
  always_comb begin
    dec_mt = 4'd15;
    case (cart_type)
      8'h00, 8'h08, 8'h09:                      dec_mt = 4'd0;
      8'h01, 8'h02, 8'h03:                      dec_mt = 4'd1;
      8'h05, 8'h06:                             dec_mt = 4'd2;
      8'h0B, 8'h0C, 8'h0D:                      dec_mt = 4'd3;
      8'h0F, 8'h10, 8'h11, 8'h12, 8'h13:        dec_mt = 4'd4;
      8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E: dec_mt = 4'd5;
      8'h20:                                    dec_mt = 4'd6;
      8'h22:                                    dec_mt = 4'd7;
      8'hFC:                                    dec_mt = 4'd8;
      8'hFD:                                    dec_mt = 4'd9;
      8'hFE:                                    dec_mt = 4'd10;
      8'hFF:                                    dec_mt = 4'd11;
      default:                                  dec_mt = 4'd15;
    endcase
    dec_bat = cart_type inside {8'h03, 8'h06, 8'h09, 8'h0D, 8'h0F, 8'h10, 8'h13,
                                8'h1B, 8'h1E, 8'h22, 8'hFF};
    dec_rtc = cart_type inside {8'h0F, 8'h10};
    dec_rum = cart_type inside {8'h1C, 8'h1D, 8'h1E};
    dec_ram = cart_type inside {8'h02, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h10, 8'h12,
                                8'h13, 8'h1A, 8'h1B, 8'h1D, 8'h1E, 8'h22, 8'hFF};
    dec_ramb = 5'd0;
    case (ram_code)
      8'h02:   dec_ramb = 5'd1;
      8'h03:   dec_ramb = 5'd4;
      8'h04:   dec_ramb = 5'd16;
      8'h05:   dec_ramb = 5'd8;
      default: dec_ramb = 5'd0;
    endcase
    // MBC2 RAM lives inside the mapper, so it never counts as external banks.
    if (!dec_ram || dec_mt == 4'd2) dec_ramb = 5'd0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ReadReq    <= 1'b0;
      ReadAddr   <= A_FIRST;
      csum       <= '0;
      hdr_sum    <= '0;
      cgb_b      <= '0;
      sgb_b      <= '0;
      cart_type  <= '0;
      rom_code   <= '0;
      ram_code   <= '0;
      abort_pend <= 1'b0;
      Error      <= 1'b0;
      ChecksumOK <= 1'b0;
      MapperType <= '0;
      RomBanks   <= '0;
      RamBanks   <= '0;
      HasRAM     <= 1'b0;
      HasBattery <= 1'b0;
      HasRTC     <= 1'b0;
      HasRumble  <= 1'b0;
      CGBMode    <= '0;
      SGBSupport <= 1'b0;
    end else if (ClkEn) begin
      case (state)
        S_IDLE: if (Start) begin
          ReadAddr   <= A_FIRST;
          csum       <= '0;
          abort_pend <= 1'b0;
        end
        S_ISSUE: if (!Abort) ReadReq <= 1'b1;
        S_WAIT: begin
          if (Abort) abort_pend <= 1'b1;
          if (ReadAck) begin
            ReadReq <= 1'b0;
            if (ReadAddr < A_LAST) begin
              csum     <= csum - ReadData - 8'd1;
              ReadAddr <= ReadAddr + ADDR_W'(1);
            end else begin
              hdr_sum <= ReadData;
            end
            case (ReadAddr)
              A_CGB:   cgb_b     <= ReadData;
              A_SGB:   sgb_b     <= ReadData;
              A_TYPE:  cart_type <= ReadData;
              A_ROM:   rom_code  <= ReadData;
              A_RAM:   ram_code  <= ReadData;
              default: ;
            endcase
          end
        end
        S_DECODE: begin
          MapperType <= dec_mt;
          RomBanks   <= (rom_code <= 8'd8) ? (10'd2 << rom_code[3:0]) : 10'd0;
          RamBanks   <= dec_ramb;
          Error      <= (dec_mt == 4'd15) || (rom_code > 8'd8);
          ChecksumOK <= (csum == hdr_sum);
          HasRAM     <= dec_ram;
          HasBattery <= dec_bat;
          HasRTC     <= dec_rtc;
          HasRumble  <= dec_rum;
          CGBMode    <= !cgb_b[7] ? 2'd0 : (cgb_b == 8'hC0) ? 2'd2 : 2'd1;
          SGBSupport <= (sgb_b == 8'h03);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gbc_cart_header_parser.sv
// Drives header images through the parser with a randomized ROM responder and
// compares every result against a table-driven model of the header rules.
module tb_gbc_cart_header_parser;
  localparam int ADDR_W = 23;

  logic              Clk, Reset_n, ClkEn, Start, Abort;
  logic              ReadReq, ReadAck, Busy, Done, Error, ChecksumOK;
  logic [ADDR_W-1:0] ReadAddr;
  logic [7:0]        ReadData;
  logic [3:0]        MapperType;
  logic [9:0]        RomBanks;
  logic [4:0]        RamBanks;
  logic              HasRAM, HasBattery, HasRTC, HasRumble, SGBSupport;
  logic [1:0]        CGBMode;

  gbc_cart_header_parser #(.ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .ClkEn(ClkEn), .Start(Start), .Abort(Abort),
    .ReadReq(ReadReq), .ReadAddr(ReadAddr), .ReadAck(ReadAck), .ReadData(ReadData),
    .Busy(Busy), .Done(Done), .Error(Error), .ChecksumOK(ChecksumOK),
    .MapperType(MapperType), .RomBanks(RomBanks), .RamBanks(RamBanks),
    .HasRAM(HasRAM), .HasBattery(HasBattery), .HasRTC(HasRTC), .HasRumble(HasRumble),
    .CGBMode(CGBMode), .SGBSupport(SGBSupport)
  );

  typedef struct {
    int mt, rb, ramb, err, ok, hr, hb, rtc, rum, cgb, sgb;
  } exp_t;

  logic [7:0] hdr [26];
  int         tests, fails;
  int         done_cnt, max_lat;
  bit         rand_en;
  int         hs_q [$];
  exp_t       prev_e;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ROM responder, clock-enable jitter and Done counting share one process.
  initial begin
    int r_cnt, r_lat, prev_addr;
    bit prev_req;
    r_cnt = 0; r_lat = 1; prev_req = 0; prev_addr = 0;
    ReadAck = 1'b0; ReadData = '0; ClkEn = 1'b1; done_cnt = 0;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        ReadAck = 1'b0; prev_req = 0; r_cnt = 0;
      end else begin
        if (ReadAck && ClkEn && prev_req) begin
          hs_q.push_back(prev_addr);
          ReadAck = 1'b0;
          r_cnt = 0;
          r_lat = $urandom_range(1, max_lat);
        end
        prev_req  = ReadReq;
        prev_addr = int'(ReadAddr);
        if (ReadReq && !ReadAck) begin
          if (r_cnt >= r_lat - 1) begin
            ReadAck = 1'b1;
            ReadData = (prev_addr >= 'h134 && prev_addr <= 'h14D) ? hdr[prev_addr - 'h134] : 8'h00;
          end else if (ClkEn) r_cnt++;
        end
      end
      ClkEn = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (Done && ClkEn) done_cnt++;
    end
  end

  task automatic make_hdr(input logic [7:0] c, input logic [7:0] s, input logic [7:0] t,
                          input logic [7:0] r, input logic [7:0] ram, input int corrupt);
    int sum;
    for (int i = 0; i < 26; i++) hdr[i] = 8'($urandom);
    hdr[15] = c; hdr[18] = s; hdr[19] = t; hdr[20] = r; hdr[21] = ram;
    sum = 0;
    for (int i = 0; i < 25; i++) sum += hdr[i];
    hdr[25] = 8'(-sum - 25 + corrupt);
  endtask

  function automatic exp_t model();
    exp_t e;
    int t, n, rc, c, sum;
    int ram_tab [6] = '{0, 0, 1, 4, 16, 8};
    t = hdr[19]; n = hdr[20]; rc = hdr[21]; c = hdr[15];
    if (t inside {0, 8, 9})                    e.mt = 0;
    else if (t inside {[1:3]})                 e.mt = 1;
    else if (t inside {5, 6})                  e.mt = 2;
    else if (t inside {['h0B:'h0D]})           e.mt = 3;
    else if (t inside {['h0F:'h13]})           e.mt = 4;
    else if (t inside {['h19:'h1E]})           e.mt = 5;
    else if (t == 'h20)                        e.mt = 6;
    else if (t == 'h22)                        e.mt = 7;
    else if (t >= 'hFC)                        e.mt = 8 + (t - 'hFC);
    else                                       e.mt = 15;
    e.hb  = int'(t inside {'h03, 'h06, 'h09, 'h0D, 'h0F, 'h10, 'h13, 'h1B, 'h1E, 'h22, 'hFF});
    e.rtc = int'(t inside {'h0F, 'h10});
    e.rum = int'(t inside {'h1C, 'h1D, 'h1E});
    e.hr  = int'(t inside {'h02, 'h03, 'h08, 'h09, 'h0C, 'h0D, 'h10, 'h12, 'h13,
                           'h1A, 'h1B, 'h1D, 'h1E, 'h22, 'hFF});
    e.rb   = (n <= 8) ? (1 << (n + 1)) : 0;
    e.err  = int'(e.mt == 15 || n > 8);
    e.ramb = (rc <= 5) ? ram_tab[rc] : 0;
    if (e.hr == 0 || e.mt == 2) e.ramb = 0;
    sum = 0;
    for (int i = 0; i < 25; i++) sum += hdr[i];
    e.ok  = int'(((-sum - 25) & 255) == hdr[25]);
    e.cgb = (c < 'h80) ? 0 : (c == 'hC0) ? 2 : 1;
    e.sgb = int'(hdr[18] == 3);
    return e;
  endfunction

  task automatic chk_out(input exp_t e);
    chk("MapperType", MapperType, e.mt);
    chk("RomBanks", RomBanks, e.rb);
    chk("RamBanks", RamBanks, e.ramb);
    chk("Error", Error, e.err);
    chk("ChecksumOK", ChecksumOK, e.ok);
    chk("HasRAM", HasRAM, e.hr);
    chk("HasBattery", HasBattery, e.hb);
    chk("HasRTC", HasRTC, e.rtc);
    chk("HasRumble", HasRumble, e.rum);
    chk("CGBMode", CGBMode, e.cgb);
    chk("SGBSupport", SGBSupport, e.sgb);
  endtask

  task automatic do_start(output int cyc);
    @(negedge Clk); #1;
    Start = 1'b1;
    cyc = 0;
    while (!Busy && cyc < 100) begin
      @(negedge Clk); #1;
      cyc++;
    end
    Start = 1'b0;
    chk("start_accepted", int'(Busy), 1);
  endtask

  task automatic run_parse(input bit chk_lat);
    int cyc, base_d, hs_base;
    exp_t e;
    base_d  = done_cnt;
    hs_base = hs_q.size();
    do_start(cyc);
    while (!Done && cyc < 4000) begin
      @(negedge Clk); #1;
      cyc++;
    end
    if (chk_lat) chk("start_to_done", cyc, 54);
    repeat (3) @(negedge Clk);
    #1;
    chk("done_pulses", done_cnt - base_d, 1);
    chk("busy_after", int'(Busy), 0);
    chk("hs_count", hs_q.size() - hs_base, 26);
    for (int i = 0; i < 26; i++)
      if (hs_base + i < hs_q.size()) chk("hs_addr", hs_q[hs_base + i], 'h134 + i);
    e = model();
    chk_out(e);
    prev_e = e;
  endtask

  task automatic wait_reads(input int n);
    int base, cyc;
    base = hs_q.size();
    cyc = 0;
    while (!((hs_q.size() - base) >= n && ReadReq && !ReadAck) && cyc < 4000) begin
      @(negedge Clk); #1;
      cyc++;
    end
    chk("reach_read", int'(cyc < 4000), 1);
  endtask

  initial begin
    int cyc, base_d;
    logic [7:0] codes [28] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h08, 8'h09,
                               8'h0B, 8'h0C, 8'h0D, 8'h0F, 8'h10, 8'h11, 8'h12, 8'h13,
                               8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h20, 8'h22,
                               8'hFC, 8'hFD, 8'hFE, 8'hFF};
    logic [7:0] cgbs [4] = '{8'h00, 8'h80, 8'hC0, 8'h84};
    tests = 0; fails = 0;
    Reset_n = 1'b0; Start = 1'b0; Abort = 1'b0;
    max_lat = 1; rand_en = 0;
    make_hdr(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge Clk);
    #1;
    chk("rst_ReadReq", ReadReq, 0);
    chk("rst_ReadAddr", int'(ReadAddr), 'h134);
    chk("rst_Busy", Busy, 0);
    chk("rst_Done", Done, 0);
    prev_e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_out(prev_e);
    #1 Reset_n = 1'b1;

    make_hdr(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0); run_parse(1);
    make_hdr(8'hC0, 8'h03, 8'h1B, 8'h06, 8'h03, 0); run_parse(0);
    make_hdr(8'h80, 8'h00, 8'h10, 8'h02, 8'h03, 0); run_parse(0);
    make_hdr(8'h00, 8'h00, 8'h06, 8'h01, 8'h03, 0); run_parse(0);
    make_hdr(8'h00, 8'h00, 8'h07, 8'h01, 8'h02, 0); run_parse(0);
    make_hdr(8'h00, 8'h00, 8'h01, 8'h09, 8'h02, 0); run_parse(0);
    make_hdr(8'h00, 8'h00, 8'h03, 8'h03, 8'h02, 1); run_parse(0);

    // Abort while a read is outstanding: the ack completes, nothing else follows.
    max_lat = 5; rand_en = 1;
    make_hdr(8'h80, 8'h03, 8'h13, 8'h05, 8'h04, 0);
    base_d = done_cnt;
    do_start(cyc);
    wait_reads(5);
    Abort = 1'b1;
    cyc = 0;
    while (Busy && cyc < 200) begin
      @(negedge Clk); #1;
      cyc++;
    end
    Abort = 1'b0;
    chk("abort_idle", int'(Busy), 0);
    repeat (5) @(negedge Clk);
    #1;
    chk("abort_ReadReq", ReadReq, 0);
    chk("abort_no_done", done_cnt - base_d, 0);
    chk_out(prev_e);

    // Asynchronous reset in the middle of read 10.
    base_d = done_cnt;
    do_start(cyc);
    wait_reads(10);
    @(negedge Clk); #2;
    Reset_n = 1'b0;
    #1;
    chk("midrst_ReadReq", ReadReq, 0);
    chk("midrst_Busy", Busy, 0);
    chk("midrst_ReadAddr", int'(ReadAddr), 'h134);
    repeat (3) @(negedge Clk);
    #2 Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    #1;
    chk("midrst_no_done", done_cnt - base_d, 0);
    chk("midrst_idle", int'(Busy), 0);
    prev_e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_out(prev_e);
    run_parse(0);

    max_lat = 7;
    for (int k = 0; k < 14; k++) begin
      logic [7:0] t;
      t = ($urandom_range(0, 3) == 0) ? 8'($urandom) : codes[$urandom_range(0, 27)];
      make_hdr(($urandom_range(0, 3) == 0) ? 8'($urandom) : cgbs[$urandom_range(0, 3)],
               ($urandom_range(0, 1) == 0) ? 8'h03 : 8'($urandom),
               t, 8'($urandom_range(0, 10)), 8'($urandom_range(0, 7)),
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 255)) : 0);
      run_parse(0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
